// File: rtl/dmem_seq_pkg.sv
// dmem_seq_pkg: access sizes, sequencer states and beat count helper
package dmem_seq_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  function automatic logic [2:0] beats_for(input logic [1:0] size);
    return size == SIZE_BYTE ? 3'd1 : size == SIZE_HALF ? 3'd2 : size == SIZE_WORD ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/dmem_seq_arb.sv
// dmem_seq_arb: port 0 priority arbiter that forces port 1 after STARVE_MAX consecutive losses
module dmem_seq_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic p0_req,
  input  logic p1_req,
  output logic gnt,
  output logic vld
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  assign vld = p0_req | p1_req;
  assign gnt = p1_req & (~p0_req | starve_cnt == CW'(STARVE_MAX));
  always_ff @(posedge clk)
    if (rst) starve_cnt <= '0;
    else if (en && vld) starve_cnt <= (p1_req && !gnt) ? starve_cnt + 1'b1 : '0;
endmodule

// File: rtl/dmem_access_sequencer.sv
// dmem_access_sequencer: two-port byte-beat sequencer for the 256-byte data memory, big-endian
// Define DMEM_SEQ_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with err.
module dmem_access_sequencer
  import dmem_seq_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_rw,
  input  logic [1:0]        p0_size,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_done,
  output logic [31:0]       p0_rdata,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_rw,
  input  logic [1:0]        p1_size,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_done,
  output logic [31:0]       p1_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_di,
  input  logic [7:0]        mem_do,
  output logic              err
);
  state_t state;
  logic port, rw, gnt, vld, s_rw, s_ill, unused_addr;
  logic [1:0] k, s_size;
  logic [2:0] beats, s_beats;
  logic [31:0] wdata, acc, acc_n, s_wdata;
  logic [ADDR_W-1:0] s_a;
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction
  dmem_seq_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk(clk), .rst(rst), .en(state == IDLE), .p0_req(p0_req), .p1_req(p1_req), .gnt(gnt), .vld(vld)
  );
  assign s_rw        = gnt ? p1_rw : p0_rw;
  assign s_size      = gnt ? p1_size : p0_size;
  assign s_a         = gnt ? p1_addr[ADDR_W-1:0] : p0_addr[ADDR_W-1:0];
  assign s_wdata     = gnt ? p1_wdata : p0_wdata;
  assign s_beats     = beats_for(s_size);
  assign unused_addr = ^{p0_addr[31:ADDR_W], p1_addr[31:ADDR_W]};
`ifdef DMEM_SEQ_ALIGN_CHECK_EN
  assign s_ill = s_beats == 3'd0 || (s_size == SIZE_HALF && s_a[0]) || (s_size == SIZE_WORD && s_a[1:0] != 2'b00);
`else
  assign s_ill = s_beats == 3'd0;
`endif
  assign acc_n    = {acc[23:0], mem_do};
  assign p0_stall = p0_req & ~p0_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      port     <= 1'b0;
      rw       <= 1'b0;
      beats    <= '0;
      k        <= '0;
      wdata    <= '0;
      acc      <= '0;
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      err      <= 1'b0;
      mem_en   <= 1'b0;
      mem_rw   <= 1'b0;
      mem_a    <= '0;
      mem_di   <= '0;
    end else begin
      case (state)
        IDLE: if (vld) begin
          port  <= gnt;
          rw    <= s_rw;
          beats <= s_beats;
          wdata <= s_wdata;
          acc   <= '0;
          k     <= '0;
          if (s_ill) begin
            state   <= DONE;
            err     <= 1'b1;
            p0_done <= ~gnt;
            p1_done <= gnt;
          end else begin
            state  <= XFER;
            mem_en <= 1'b1;
            mem_rw <= s_rw;
            mem_a  <= s_a;
            mem_di <= byte_of(s_wdata, 2'(s_beats - 3'd1));
          end
        end
        XFER: begin
          acc <= acc_n;
          if ({1'b0, k} == beats - 3'd1) begin
            state    <= DONE;
            mem_en   <= 1'b0;
            mem_rw   <= 1'b0;
            p0_done  <= ~port;
            p1_done  <= port;
            p0_rdata <= port | rw ? '0 : acc_n;
            p1_rdata <= ~port | rw ? '0 : acc_n;
          end else begin
            k      <= k + 2'd1;
            mem_a  <= mem_a + 1'b1;
            mem_di <= byte_of(wdata, 2'(beats - 3'd2 - {1'b0, k}));
          end
        end
        DONE: begin
          state    <= IDLE;
          p0_done  <= 1'b0;
          p1_done  <= 1'b0;
          p0_rdata <= '0;
          p1_rdata <= '0;
          err      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_sequencer.sv
// tb_dmem_access_sequencer: vector table, corner sequences and randomized model check
module tb_dmem_access_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic p0_req = 0, p0_rw = 0, p1_req = 0, p1_rw = 0;
  logic [1:0] p0_size = 0, p1_size = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic p0_done, p1_done, p0_stall, mem_en, mem_rw, err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [7:0] mem_a, mem_di, mem_do;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dmem_access_sequencer dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do), .err(err)
  );
  assign mem_do = mem[mem_a];
  always @(posedge clk) if (mem_en && mem_rw) mem[mem_a] <= mem_di;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, big-endian byte order, latency = beats + 2
  function automatic void model(input bit rw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w,
                                output logic [31:0] rd, output bit e, output int lat);
    int n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
    bit ill = n == 0;
`ifdef DMEM_SEQ_ALIGN_CHECK_EN
    if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) ill = 1;
`endif
    rd = 0;
    e = ill;
    lat = 2;
    if (!ill) begin
      lat = n + 2;
      for (int j = 0; j < n; j++) begin
        int idx = (int'(a[7:0]) + j) % 256;
        if (rw) ref_mem[idx] = 8'((w >> (8 * (n - 1 - j))) & 32'hFF);
        else rd = (rd << 8) | 32'(ref_mem[idx]);
      end
    end
  endfunction

  task automatic run_txn(input bit p, input bit rw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w,
                         output logic [31:0] rd, output bit e, output int lat, output bit en_seen);
    if (!p) begin p0_req = 1; p0_rw = rw; p0_size = sz; p0_addr = a; p0_wdata = w; end
    else begin p1_req = 1; p1_rw = rw; p1_size = sz; p1_addr = a; p1_wdata = w; end
    rd = 0; e = 0; lat = 0; en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        p0_addr = $urandom; p0_wdata = $urandom; p1_addr = $urandom; p1_wdata = $urandom;
      end
      en_seen |= mem_en;
      if (p ? p1_done : p0_done) begin
        rd = p ? p1_rdata : p0_rdata;
        e = err;
        lat = i + 2;
        break;
      end
    end
    p0_req = 0; p1_req = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit p; bit rw; logic [1:0] sz; logic [31:0] a; logic [31:0] w;
    logic [31:0] rd; bit e; int lat;
  } vec_t;
  vec_t tv [10];

  initial begin
    logic [31:0] rd, mrd;
    bit e, me, en_seen;
    int lat, mlat, got, bad;
    int order [$];
    int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    tv[0] = '{0, 1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 6};
    tv[1] = '{0, 0, 2'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 6};
    tv[2] = '{0, 0, 2'd1, 32'h12, 32'h0, 32'h0000BEEF, 0, 4};
    tv[3] = '{1, 0, 2'd0, 32'h11, 32'h0, 32'h000000AD, 0, 3};
`ifdef DMEM_SEQ_ALIGN_CHECK_EN
    tv[4] = '{1, 1, 2'd2, 32'hFE, 32'h01020304, 32'h0, 1, 2};
    tv[5] = '{0, 0, 2'd2, 32'hFE, 32'h0, 32'h0, 1, 2};
    tv[6] = '{0, 0, 2'd0, 32'h00, 32'h0, 32'h0, 0, 3};
`else
    tv[4] = '{1, 1, 2'd2, 32'hFE, 32'h01020304, 32'h0, 0, 6};
    tv[5] = '{0, 0, 2'd2, 32'hFE, 32'h0, 32'h01020304, 0, 6};
    tv[6] = '{0, 0, 2'd0, 32'h00, 32'h0, 32'h00000003, 0, 3};
`endif
    tv[7] = '{0, 0, 2'd3, 32'h20, 32'h0, 32'h0, 1, 2};
    tv[8] = '{1, 1, 2'd1, 32'h30, 32'h1234A5C3, 32'h0, 0, 4};
    tv[9] = '{1, 0, 2'd1, 32'h30, 32'h0, 32'h0000A5C3, 0, 4};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_p0_done", p0_done, 0);
    chk("rst_p1_done", p1_done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_err", err, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p0_stall", p0_stall, 0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tv[i].p, tv[i].rw, tv[i].sz, tv[i].a, tv[i].w, rd, e, lat, en_seen);
      model(tv[i].rw, tv[i].sz, tv[i].a, tv[i].w, mrd, me, mlat);
      chk($sformatf("tv%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("tv%0d_err", i), 32'(e), 32'(tv[i].e));
      chk($sformatf("tv%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("tv%0d_mem_en_seen", i), 32'(en_seen), 32'(!tv[i].e));
    end
    chk("word_wr_bytes_10", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEADBEEF);
`ifdef DMEM_SEQ_ALIGN_CHECK_EN
    chk("wrap_wr_bytes", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'h0);
`else
    chk("wrap_wr_bytes", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'h01020304);
`endif

    // reset lands while the second beat of a word write is on the bus
    p0_req = 1; p0_rw = 1; p0_size = 2'd2; p0_addr = 32'h40; p0_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_beat1_en", mem_en, 1);
    chk("abort_beat1_a", 32'(mem_a), 32'h41);
    rst = 1;
    @(posedge clk); #1;
    chk("abort_mem_en", mem_en, 0);
    chk("abort_done", p0_done, 0);
    chk("abort_err", err, 0);
    rst = 0; p0_req = 0;
    ref_mem[8'h40] = 8'hCA;
    ref_mem[8'h41] = 8'hFE;
    chk("abort_bytes", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hCAFE0000);
    run_txn(0, 0, 2'd2, 32'h40, 32'h0, rd, e, lat, en_seen);
    chk("after_abort_rdata", rd, 32'hCAFE0000);
    chk("after_abort_latency", lat, 6);

    // both ports hammer continuously; port 1 must break through every fifth grant
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    p0_req = 1; p0_rw = 0; p0_size = 2'd0; p0_addr = 32'h10;
    p1_req = 1; p1_rw = 0; p1_size = 2'd0; p1_addr = 32'h11;
    got = 0;
    for (int c = 0; c < 200 && got < 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) chk("p0_stall_waiting", p0_stall, 1);
      if (p0_done && p1_done) chk("dual_done", 1, 0);
      if (p0_done) begin order.push_back(0); got++; end
      else if (p1_done) begin order.push_back(1); got++; end
    end
    p0_req = 0; p1_req = 0;
    @(posedge clk); #1;
    chk("starve_grant_count", got, 10);
    for (int i = 0; i < 10 && i < order.size(); i++) chk($sformatf("starve_order%0d", i), order[i], exp_order[i]);

    for (int i = 0; i < 80; i++) begin
      bit p = 1'($urandom_range(0, 1));
      bit rw = 1'($urandom_range(0, 1));
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [31:0] a = $urandom_range(0, 255);
      logic [31:0] w = $urandom;
      model(rw, sz, a, w, mrd, me, mlat);
      run_txn(p, rw, sz, a, w, rd, e, lat, en_seen);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(me));
      chk($sformatf("rnd%0d_latency", i), lat, mlat);
      chk($sformatf("rnd%0d_mem_en_seen", i), 32'(en_seen), 32'(!me));
    end
    bad = 0;
    for (int j = 0; j < 256; j++) if (mem[j] !== ref_mem[j]) bad++;
    chk("mem_final_mismatched_bytes", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
